// File: rtl/tdt_dmi_pkg.sv
// Shared definitions for the DMI request arbiter: FSM encodings, command op codes, flush length.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdt_dmi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_FLUSH = 3'd4
  } dmi_state_e;

  localparam logic [1:0] WR_FLG_RD = 2'b01;
  localparam logic [1:0] WR_FLG_WR = 2'b10;

  // Cycles spent in FLUSH so the master's reset synchronizer can settle.
  localparam int FLUSH_CYCLES = 4;

  // Only read and write reach the APB master; other codes are answered locally with an error.
  function automatic logic op_is_valid(input logic [1:0] flg);
    return (flg == WR_FLG_RD) || (flg == WR_FLG_WR);
  endfunction

endpackage

// File: rtl/tdt_rr_arbiter.sv
// Round-robin one-hot pick: first set request at or above ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module tdt_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int j;
    any = 1'b0;
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/tdt_dmi_req_arbiter.sv
// Shares one DMI command port among NUM_REQ requesters, round-robin, with timeout/abort hard-reset recovery.
// Latency: grant edge -> cmd_vld next edge; apb_wr_ready edge -> resp_vld next edge.
// Backpressure: one transfer in flight; requesters hold req_vld until req_gnt, master completes via apb_wr_ready.
module tdt_dmi_req_arbiter
  import tdt_dmi_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DTM_ADDR_WIDTH = 18,
  parameter int TIMEOUT_W      = 10
) (
  input  logic                              tck,
  input  logic                              trst_b,
  input  logic [NUM_REQ-1:0]                req_vld,
  input  logic [NUM_REQ*DTM_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*2-1:0]              req_wr_flg,
  input  logic [NUM_REQ*32-1:0]             req_wdata,
  output logic [NUM_REQ-1:0]                req_gnt,
  output logic [NUM_REQ-1:0]                resp_vld,
  output logic [31:0]                       resp_rdata,
  output logic                              resp_err,
  input  logic                              abort_req,
  output logic                              cmd_vld,
  output logic [DTM_ADDR_WIDTH-1:0]         addr,
  output logic [1:0]                        wr_flg,
  output logic [31:0]                       wdata,
  output logic                              dmihardreset,
  input  logic [31:0]                       rdata,
  input  logic                              apb_wr_ready,
  output logic                              busy
);

  localparam int PW = $clog2(NUM_REQ);
  // Last WAIT count before giving up: the transfer fails after 2^TIMEOUT_W-1 wait cycles.
  localparam logic [TIMEOUT_W-1:0] TO_LAST    = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] FLUSH_LAST = TIMEOUT_W'(FLUSH_CYCLES - 1);

  dmi_state_e                state_q, state_d;
  logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]             owner_q, owner_d;
  logic [TIMEOUT_W-1:0]      cnt_q, cnt_d;        // WAIT timeout and FLUSH length share this counter
  logic                      pend_q, pend_d;      // owner still owed a response after FLUSH
  logic [NUM_REQ-1:0]        req_gnt_q, req_gnt_d;
  logic [NUM_REQ-1:0]        resp_vld_q, resp_vld_d;
  logic [31:0]               resp_rdata_q, resp_rdata_d;
  logic                      resp_err_q, resp_err_d;
  logic                      cmd_vld_q, cmd_vld_d;
  logic [DTM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]                wr_flg_q, wr_flg_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      hrst_q, hrst_d;

  logic                      arb_any;
  logic [NUM_REQ-1:0]        arb_gnt;
  logic [PW-1:0]             arb_idx;
  logic [DTM_ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]                sel_flg;
  logic [31:0]               sel_wdata;

  tdt_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req (req_vld),
    .ptr (rr_ptr_q),
    .any (arb_any),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // One-hot mux of the winning requester's command fields.
  always_comb begin
    sel_addr  = '0;
    sel_flg   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = req_addr[i*DTM_ADDR_WIDTH +: DTM_ADDR_WIDTH];
        sel_flg   = req_wr_flg[i*2 +: 2];
        sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  // Next-state and output computation; abort_req overrides every state.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    req_gnt_d    = '0;
    resp_vld_d   = '0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    cmd_vld_d    = 1'b0;
    addr_d       = addr_q;
    wr_flg_d     = wr_flg_q;
    wdata_d      = wdata_q;
    hrst_d       = 1'b0;

    if (abort_req) begin
      hrst_d  = 1'b1;
      state_d = ST_FLUSH;
      cnt_d   = '0;
      case (state_q)
        ST_ISSUE, ST_WAIT: begin
          pend_d       = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end
        ST_RESP: pend_d = 1'b1;   // completed result is still delivered after the flush
        ST_IDLE: pend_d = 1'b0;
        default: ;                // FLUSH restart keeps whatever is owed
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            req_gnt_d = arb_gnt;
            owner_d   = arb_idx;
            addr_d    = sel_addr;
            wr_flg_d  = sel_flg;
            wdata_d   = sel_wdata;
            rr_ptr_d  = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            if (op_is_valid(sel_flg)) begin
              state_d = ST_ISSUE;
            end else begin
              state_d      = ST_RESP;
              resp_err_d   = 1'b1;
              resp_rdata_d = '0;
            end
          end
        end
        ST_ISSUE: begin
          cmd_vld_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end
        ST_WAIT: begin
          if (apb_wr_ready) begin
            resp_rdata_d = rdata;
            resp_err_d   = 1'b0;
            state_d      = ST_RESP;
          end else if (cnt_q == TO_LAST) begin
            hrst_d       = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            pend_d       = 1'b1;
            cnt_d        = '0;
            state_d      = ST_FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            state_d = pend_q ? ST_RESP : ST_IDLE;
            pend_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          resp_vld_d[owner_q] = 1'b1;
          state_d             = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge tck) begin
    if (!trst_b) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      req_gnt_q    <= '0;
      resp_vld_q   <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      cmd_vld_q    <= 1'b0;
      addr_q       <= '0;
      wr_flg_q     <= '0;
      wdata_q      <= '0;
      hrst_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      req_gnt_q    <= req_gnt_d;
      resp_vld_q   <= resp_vld_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      cmd_vld_q    <= cmd_vld_d;
      addr_q       <= addr_d;
      wr_flg_q     <= wr_flg_d;
      wdata_q      <= wdata_d;
      hrst_q       <= hrst_d;
    end
  end

  assign req_gnt      = req_gnt_q;
  assign resp_vld     = resp_vld_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign cmd_vld      = cmd_vld_q;
  assign addr         = addr_q;
  assign wr_flg       = wr_flg_q;
  assign wdata        = wdata_q;
  assign dmihardreset = hrst_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tdt_dmi_req_arbiter.sv
// Bench for the DMI request arbiter: per-cycle vector table plus alternation and timeout sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_tdt_dmi_req_arbiter;

  localparam logic [17:0] A0 = 18'h00011;
  localparam logic [17:0] A1 = 18'h2A5A5;
  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_0000;

  logic        tck = 1'b0;
  logic        trst_b;
  logic [1:0]  req_vld;
  logic [1:0]  flg0, flg1;
  logic        abort_req;
  logic [31:0] rdata;
  logic        apb_wr_ready;

  logic [1:0]  req_gnt, resp_vld, wr_flg;
  logic [31:0] resp_rdata, wdata;
  logic        resp_err, cmd_vld, dmihardreset, busy;
  logic [17:0] addr;

  int checks = 0;
  int errors = 0;

  always #5 tck = ~tck;

  tdt_dmi_req_arbiter #(.NUM_REQ(2), .DTM_ADDR_WIDTH(18), .TIMEOUT_W(4)) dut (
    .tck          (tck),
    .trst_b       (trst_b),
    .req_vld      (req_vld),
    .req_addr     ({A1, A0}),
    .req_wr_flg   ({flg1, flg0}),
    .req_wdata    ({W1, W0}),
    .req_gnt      (req_gnt),
    .resp_vld     (resp_vld),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .abort_req    (abort_req),
    .cmd_vld      (cmd_vld),
    .addr         (addr),
    .wr_flg       (wr_flg),
    .wdata        (wdata),
    .dmihardreset (dmihardreset),
    .rdata        (rdata),
    .apb_wr_ready (apb_wr_ready),
    .busy         (busy)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  f0, f1;
    logic        ab, rdy;
    logic [31:0] rdat;
    logic [1:0]  e_gnt;
    logic        e_cmd, e_hr;
    logic [1:0]  e_rvld;
    logic        e_err;
    logic [31:0] e_rdat;
    logic        e_busy;
    logic [17:0] e_addr;
    logic [1:0]  e_flg;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic rst_n, input logic [1:0] req, input logic [1:0] f0, input logic [1:0] f1,
                     input logic ab, input logic rdy, input logic [31:0] rdat,
                     input logic [1:0] e_gnt, input logic e_cmd, input logic e_hr, input logic [1:0] e_rvld,
                     input logic e_err, input logic [31:0] e_rdat, input logic e_busy,
                     input logic [17:0] e_addr, input logic [1:0] e_flg, input logic [31:0] e_wd);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.f0 = f0; v.f1 = f1; v.ab = ab; v.rdy = rdy; v.rdat = rdat;
    v.e_gnt = e_gnt; v.e_cmd = e_cmd; v.e_hr = e_hr; v.e_rvld = e_rvld; v.e_err = e_err;
    v.e_rdat = e_rdat; v.e_busy = e_busy; v.e_addr = e_addr; v.e_flg = e_flg; v.e_wd = e_wd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Advance one edge; outputs are then read 1 time unit after it.
  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic do_reset();
    trst_b = 1'b0; req_vld = '0; abort_req = 1'b0; apb_wr_ready = 1'b0;
    step();
    trst_b = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int ngnt, nresp, last_cmd, cur, n, m, hr_cnt;
  logic [31:0] rd_sent;
  logic        stab_bad;

  initial begin
    trst_b = 1'b0; req_vld = '0; flg0 = '0; flg1 = '0;
    abort_req = 1'b0; rdata = '0; apb_wr_ready = 1'b0;

    // rst req f0 f1 ab rdy rdat | gnt cmd hr rvld err rdat busy addr flg wd
    row(0, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 32'h0, 0, 18'h0, 2'b00, 32'h0);
    // single read from requester 0, ready 5 cycles after cmd_vld
    row(1, 2'b01, 2'b01, 2'b00, 0, 0, 32'h0, 2'b01, 0, 0, 2'b00, 0, 32'h0, 1, A0, 2'b01, W0);
    row(1, 2'b00, 2'b01, 2'b00, 0, 0, 32'h0, 2'b00, 1, 0, 2'b00, 0, 32'h0, 1, A0, 2'b01, W0);
    for (int i = 0; i < 5; i++)
      row(1, 2'b00, 2'b01, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 32'h0, 1, A0, 2'b01, W0);
    row(1, 2'b00, 2'b01, 2'b00, 0, 1, 32'hDEADBEEF, 2'b00, 0, 0, 2'b00, 0, 32'h0, 1, A0, 2'b01, W0);
    row(1, 2'b00, 2'b01, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 2'b01, 0, 32'hDEADBEEF, 0, A0, 2'b01, W0);
    row(1, 2'b00, 2'b01, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 32'h0, 0, A0, 2'b01, W0);
    // no-op (11) from requester 1: local error response, no cmd_vld
    row(1, 2'b10, 2'b01, 2'b11, 0, 0, 32'h0, 2'b10, 0, 0, 2'b00, 0, 32'h0, 1, A1, 2'b11, W1);
    row(1, 2'b00, 2'b01, 2'b11, 0, 0, 32'h0, 2'b00, 0, 0, 2'b10, 1, 32'h0, 0, A1, 2'b11, W1);
    row(1, 2'b00, 2'b01, 2'b11, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 32'h0, 0, A1, 2'b11, W1);
    // write from requester 0, then reset during WAIT
    row(1, 2'b01, 2'b10, 2'b11, 0, 0, 32'h0, 2'b01, 0, 0, 2'b00, 0, 32'h0, 1, A0, 2'b10, W0);
    row(1, 2'b00, 2'b10, 2'b11, 0, 0, 32'h0, 2'b00, 1, 0, 2'b00, 0, 32'h0, 1, A0, 2'b10, W0);
    row(1, 2'b00, 2'b10, 2'b11, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 32'h0, 1, A0, 2'b10, W0);
    row(0, 2'b00, 2'b10, 2'b11, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 32'h0, 0, 18'h0, 2'b00, 32'h0);
    // both request right after reset: pointer back at 0 so requester 0 wins
    row(1, 2'b11, 2'b01, 2'b01, 0, 0, 32'h0, 2'b01, 0, 0, 2'b00, 0, 32'h0, 1, A0, 2'b01, W0);
    row(1, 2'b10, 2'b01, 2'b01, 0, 0, 32'h0, 2'b00, 1, 0, 2'b00, 0, 32'h0, 1, A0, 2'b01, W0);
    row(1, 2'b10, 2'b01, 2'b01, 0, 1, 32'h12345678, 2'b00, 0, 0, 2'b00, 0, 32'h0, 1, A0, 2'b01, W0);
    row(1, 2'b10, 2'b01, 2'b01, 0, 0, 32'h0, 2'b00, 0, 0, 2'b01, 0, 32'h12345678, 0, A0, 2'b01, W0);
    row(1, 2'b10, 2'b01, 2'b01, 0, 0, 32'h0, 2'b10, 0, 0, 2'b00, 0, 32'h0, 1, A1, 2'b01, W1);
    row(1, 2'b00, 2'b01, 2'b01, 0, 0, 32'h0, 2'b00, 1, 0, 2'b00, 0, 32'h0, 1, A1, 2'b01, W1);
    row(1, 2'b00, 2'b01, 2'b01, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 32'h0, 1, A1, 2'b01, W1);
    // abort mid-WAIT, late ready in FLUSH is ignored, owner gets an error response
    row(1, 2'b00, 2'b01, 2'b01, 1, 0, 32'h0, 2'b00, 0, 1, 2'b00, 0, 32'h0, 1, A1, 2'b01, W1);
    row(1, 2'b00, 2'b01, 2'b01, 0, 1, 32'hFFFFFFFF, 2'b00, 0, 0, 2'b00, 0, 32'h0, 1, A1, 2'b01, W1);
    for (int i = 0; i < 3; i++)
      row(1, 2'b00, 2'b01, 2'b01, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 32'h0, 1, A1, 2'b01, W1);
    row(1, 2'b00, 2'b01, 2'b01, 0, 0, 32'h0, 2'b00, 0, 0, 2'b10, 1, 32'h0, 0, A1, 2'b01, W1);
    row(1, 2'b00, 2'b01, 2'b01, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 32'h0, 0, A1, 2'b01, W1);

    foreach (tbl[i]) begin
      trst_b = tbl[i].rst_n; req_vld = tbl[i].req; flg0 = tbl[i].f0; flg1 = tbl[i].f1;
      abort_req = tbl[i].ab; apb_wr_ready = tbl[i].rdy; rdata = tbl[i].rdat;
      step();
      chk($sformatf("row%0d_ctl", i),
          64'({req_gnt, cmd_vld, dmihardreset, resp_vld, busy, addr, wr_flg, wdata}),
          64'({tbl[i].e_gnt, tbl[i].e_cmd, tbl[i].e_hr, tbl[i].e_rvld, tbl[i].e_busy,
               tbl[i].e_addr, tbl[i].e_flg, tbl[i].e_wd}));
      if (tbl[i].e_rvld != 2'b00)
        chk($sformatf("row%0d_resp", i), 64'({resp_err, resp_rdata}), 64'({tbl[i].e_err, tbl[i].e_rdat}));
    end
    trst_b = 1'b1; abort_req = 1'b0; apb_wr_ready = 1'b0;

    // Both requesters held: grants alternate 0,1,0,1 with gaps between cmd pulses.
    do_reset();
    req_vld = 2'b11; flg0 = 2'b01; flg1 = 2'b10;
    ngnt = 0; nresp = 0; last_cmd = -10; cur = 0; rd_sent = '0; stab_bad = 1'b0;
    for (int cyc = 0; cyc < 200 && nresp < 4; cyc++) begin
      step();
      apb_wr_ready = 1'b0;
      if (req_gnt != 2'b00) begin
        chk($sformatf("alt_gnt%0d", ngnt), 64'(req_gnt), 64'(2'b01 << (ngnt % 2)));
        cur = ngnt % 2;
        ngnt++;
        stab_bad = 1'b0;
      end
      if (busy && ngnt > 0 && (addr !== (cur ? A1 : A0) || wdata !== (cur ? W1 : W0)))
        stab_bad = 1'b1;
      if (cmd_vld) begin
        chk("alt_cmd_gap_ok", 64'(cyc - last_cmd >= 2), 64'(1));
        last_cmd = cyc;
        rd_sent = 32'hA000_0000 | 32'(nresp);
        rdata = rd_sent;
        apb_wr_ready = 1'b1;
      end
      if (resp_vld != 2'b00) begin
        chk($sformatf("alt_resp%0d", nresp), 64'({resp_vld, resp_err, resp_rdata}),
            64'({2'b01 << cur, 1'b0, rd_sent}));
        chk($sformatf("alt_stable%0d", nresp), 64'(stab_bad), 64'(0));
        nresp++;
      end
    end
    chk("alt_done_resp_count", 64'(nresp), 64'(4));
    req_vld = 2'b00; apb_wr_ready = 1'b0;

    // Write with no ready: timeout after 15 WAIT cycles, 4 FLUSH cycles, error response.
    do_reset();
    req_vld = 2'b01; flg0 = 2'b10;
    step();
    chk("to_gnt", 64'(req_gnt), 64'(2'b01));
    req_vld = 2'b00;
    step();
    chk("to_cmd", 64'(cmd_vld), 64'(1));
    n = 0;
    while (n < 40 && !dmihardreset) begin step(); n++; end
    chk("to_wait_cycles", 64'(n), 64'(15));
    hr_cnt = 1; m = 0;
    while (m < 20 && resp_vld == 2'b00) begin
      step(); m++;
      if (dmihardreset) hr_cnt++;
    end
    chk("to_flush_to_resp", 64'(m), 64'(5));
    chk("to_resp", 64'({resp_vld, resp_err, resp_rdata}), 64'({2'b01, 1'b1, 32'h0}));
    chk("to_hr_pulses", 64'(hr_cnt), 64'(1));

    // Following request is served normally.
    req_vld = 2'b10; flg1 = 2'b01;
    step();
    chk("post_gnt", 64'(req_gnt), 64'(2'b10));
    req_vld = 2'b00;
    step();
    chk("post_cmd", 64'({cmd_vld, addr, wr_flg}), 64'({1'b1, A1, 2'b01}));
    rdata = 32'h0BAD_F00D; apb_wr_ready = 1'b1;
    step();
    apb_wr_ready = 1'b0;
    step();
    chk("post_resp", 64'({resp_vld, resp_err, resp_rdata}), 64'({2'b10, 1'b0, 32'h0BAD_F00D}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
